// File: rtl/shift_deserializer_if.sv
// Serial-in / parallel-out bundle for shift_deserializer.
// master = link driver and word consumer, slave = the deserializer.
interface shift_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             s_data;
  logic             s_valid;
  logic             s_start;
  logic             dir;
  logic [WIDTH-1:0] D;
  logic             d_valid;
  logic             d_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output s_data, s_valid, s_start, dir, d_ready, clr_overrun,
    input  D, d_valid, busy, overrun
  );

  modport slave (
    input  s_data, s_valid, s_start, dir, d_ready, clr_overrun,
    output D, d_valid, busy, overrun
  );
endinterface

// File: rtl/shift_deserializer.sv
// Rebuilds framed serial bits (MSB- or LSB-first) into a parallel word and
// holds it on a valid/ready port; a word finishing while the port is stalled is dropped.
module shift_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_deserializer_if.slave bus
);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             d_valid_reg, d_valid_next;
  logic             overrun_reg, overrun_next;

  logic             complete;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] start_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sh_reg      <= '0;
      dir_reg     <= 1'b0;
      d_reg       <= '0;
      d_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sh_reg      <= sh_next;
      dir_reg     <= dir_next;
      d_reg       <= d_next;
      d_valid_reg <= d_valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sh_next      = sh_reg;
    dir_next     = dir_reg;
    d_next       = d_reg;
    d_valid_next = d_valid_reg;
    overrun_next = overrun_reg;
    complete     = 1'b0;

    // Shift direction follows the order latched at the start bit, not the live input.
    shifted = dir_reg ? {bus.s_data, sh_reg[MSB:1]} : {sh_reg[MSB-1:0], bus.s_data};
    start_word = '0;
    start_word[bus.dir ? MSB : 0] = bus.s_data;

    case (state_reg)
      IDLE: begin
        if (bus.s_valid && bus.s_start) begin
          sh_next    = start_word;
          dir_next   = bus.dir;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_valid) begin
          if (bus.s_start) begin
            sh_next  = start_word;
            dir_next = bus.dir;
            cnt_next = CW'(1);
          end else if (cnt_reg == CW'(WIDTH - 1)) begin
            complete   = 1'b1;
            sh_next    = shifted;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            sh_next  = shifted;
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (d_valid_reg && bus.d_ready)
      d_valid_next = 1'b0;

    // Clear is applied first so that a drop on the same edge keeps overrun set.
    if (bus.clr_overrun)
      overrun_next = 1'b0;

    if (complete) begin
      if (!d_valid_reg || bus.d_ready) begin
        d_next       = shifted;
        d_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign bus.D       = d_reg;
  assign bus.d_valid = d_valid_reg;
  assign bus.busy    = (state_reg == SHIFT);
  assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed checks of shift_deserializer: bit order, gaps, overrun, resync, async reset.
module tb_shift_deserializer;
  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   fail_cnt;

  shift_deserializer_if #(.WIDTH(4)) bus ();

  shift_deserializer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Present one serial slot, let the DUT sample it, then settle 1 time unit.
  task automatic step(input logic v, input logic s, input logic d);
    bus.s_valid = v;
    bus.s_start = s;
    bus.s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [3:0] bits);
    step(1'b1, 1'b1, bits[3]);
    step(1'b1, 1'b0, bits[2]);
    step(1'b1, 1'b0, bits[1]);
    step(1'b1, 1'b0, bits[0]);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n           = 1'b0;
    bus.s_data      = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_start     = 1'b0;
    bus.dir         = 1'b0;
    bus.d_ready     = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_D", bus.D, 16'h0);
    check("rst_valid", bus.d_valid, 16'h0);
    check("rst_busy", bus.busy, 16'h0);
    check("rst_overrun", bus.overrun, 16'h0);
    rst_n = 1'b1;

    // 1: MSB-first 1,0,1,0 continuous
    bus.d_ready = 1'b1;
    bus.dir     = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    check("t1_busy_b1", bus.busy, 16'h1);
    step(1'b1, 1'b0, 1'b0);
    check("t1_busy_b2", bus.busy, 16'h1);
    step(1'b1, 1'b0, 1'b1);
    check("t1_busy_b3", bus.busy, 16'h1);
    check("t1_valid_b3", bus.d_valid, 16'h0);
    step(1'b1, 1'b0, 1'b0);
    check("t1_D", bus.D, 16'hA);
    check("t1_valid", bus.d_valid, 16'h1);
    check("t1_busy_done", bus.busy, 16'h0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_consumed", bus.d_valid, 16'h0);
    check("t1_D_hold", bus.D, 16'hA);

    // 2: LSB-first with two idle slots after bit 2; dir toggled mid-frame
    bus.dir = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    bus.dir = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("t2_gap1_busy", bus.busy, 16'h1);
    step(1'b0, 1'b0, 1'b1);
    check("t2_gap2_busy", bus.busy, 16'h1);
    check("t2_gap2_valid", bus.d_valid, 16'h0);
    step(1'b1, 1'b0, 1'b1);
    check("t2_valid_b3", bus.d_valid, 16'h0);
    step(1'b1, 1'b0, 1'b0);
    check("t2_D", bus.D, 16'h5);
    check("t2_valid", bus.d_valid, 16'h1);
    step(1'b0, 1'b0, 1'b0);

    // 3: stalled consumer, back-to-back frames
    bus.d_ready = 1'b0;
    bus.dir     = 1'b0;
    frame4(4'b1100);
    check("t3_D_first", bus.D, 16'hC);
    frame4(4'b0011);
    check("t3_D_kept", bus.D, 16'hC);
    check("t3_valid", bus.d_valid, 16'h1);
    check("t3_overrun", bus.overrun, 16'h1);
    bus.clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    bus.clr_overrun = 1'b0;
    check("t3_ovr_clr", bus.overrun, 16'h0);
    check("t3_valid_held", bus.d_valid, 16'h1);

    // 4: accept on the same edge a new word completes
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    bus.d_ready = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("t4_D", bus.D, 16'h6);
    check("t4_valid", bus.d_valid, 16'h1);
    check("t4_overrun", bus.overrun, 16'h0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_consumed", bus.d_valid, 16'h0);

    // 5: resync discards partial word
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("t5_busy_resync", bus.busy, 16'h1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_valid_early", bus.d_valid, 16'h0);
    step(1'b1, 1'b0, 1'b1);
    check("t5_D", bus.D, 16'h1);
    check("t5_valid", bus.d_valid, 16'h1);
    step(1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_D", bus.D, 16'h0);
    check("t6_rst_busy", bus.busy, 16'h0);
    check("t6_rst_valid", bus.d_valid, 16'h0);
    check("t6_rst_overrun", bus.overrun, 16'h0);
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("t6_idle_ignores", bus.busy, 16'h0);
    frame4(4'b1001);
    check("t6_D", bus.D, 16'h9);
    check("t6_valid", bus.d_valid, 16'h1);
    step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receiving end of the serial link driven by the team's 4-bit parallel-load shifter.
- Collects framed serial bits and rebuilds the parallel word, MSB-first or LSB-first.
- Presents each completed word on a registered valid/ready output port.
- Sits between the shifter's serial output and any downstream parallel consumer; flags words dropped by a stalled consumer.

Parameters:
WIDTH, 4, word length in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  asynchronous active-low reset
s_data  input  1  serial data bit
s_valid  input  1  s_data is valid this cycle
s_start  input  1  marks the first bit of a frame; only meaningful when s_valid=1
dir  input  1  bit order, sampled with the start bit: 0 = MSB first, 1 = LSB first
D  output  WIDTH  reconstructed parallel word (registered)
d_valid  output  1  D holds an unconsumed word
d_ready  input  1  consumer accepts D at this clock edge when d_valid=1
busy  output  1  a frame is in progress (state SHIFT)
overrun  output  1  sticky: a completed word was dropped
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, shift reg=0, D=0, d_valid=0, overrun=0, busy=0. Reset mid-frame discards the partial word; a held D is lost.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- IDLE:
  - Bits with s_valid=1 and s_start=0 are ignored.
  - On s_valid=1 and s_start=1: capture s_data as bit 1, latch dir, counter=1, go to SHIFT.
- SHIFT, s_valid=0: hold all state; counter does not advance.
- SHIFT, s_valid=1 and s_start=1 (resync): discard the partial word, treat the bit as bit 1 of a new frame, latch dir, counter=1, stay in SHIFT.
- SHIFT, s_valid=1 and s_start=0:
  - Shift the bit in. MSB-first: shift reg left, new bit into bit 0. LSB-first: shift reg right, new bit into bit WIDTH-1.
  - Increment counter.
- Word completion:
  - Occurs at the edge that samples bit number WIDTH.
  - The full word (including that bit) is delivered, counter returns to 0, state returns to IDLE.
  - The next cycle can accept a new start bit, so back-to-back frames have zero gap.
- Delivery at completion:
  - If d_valid=0, or d_valid=1 with d_ready=1 at the same edge: D loads the word and d_valid=1 from the next cycle. Latency is 1 cycle after the last bit is sampled.
  - If d_valid=1 and d_ready=0: the new word is dropped, D is unchanged, overrun=1.
- Output handshake:
  - d_valid=1 and d_ready=1 with no completion: d_valid clears next cycle.
  - D holds its last value after it is consumed.
  - d_ready is ignored while d_valid=0.
- overrun:
  - Set by a drop; cleared only by clr_overrun=1.
  - If set and clear occur at the same edge, set wins.
- Bit order check: a frame whose bits arrive in time order 1,0,1,0 gives D=4'b1010 with dir=0 and D=4'b0101 with dir=1.
- dir changes mid-frame have no effect until the next start bit.
- Counter width: $clog2(WIDTH+1) bits; no wrap is possible because completion returns it to 0.

Test Plan:
1. Reset, then d_ready=1. Frame bits 1,0,1,0 with s_start on the first bit, dir=0, s_valid=1 continuously. Required: D=4'b1010 and d_valid=1 exactly one cycle after bit 4; d_valid=0 the following cycle; busy=1 for 3 cycles.
2. Same bits with dir=1 and 2 idle cycles (s_valid=0) inserted after bit 2. Required: D=4'b0101; completion delayed by exactly 2 cycles; busy held through the gap.
3. d_ready=0. Send frame 1100, then immediately a back-to-back frame 0011. Required: D stays 4'b1100, d_valid=1, overrun=1. Then pulse clr_overrun with no drop pending. Required: overrun=0.
4. Pending word 1100 with d_ready=1 asserted on the same edge that frame 0110 completes. Required: D=4'b0110, d_valid stays 1, overrun=0.
5. Send bits 1,1 then assert s_start with bit 0, then bits 0,0,1. Required: the partial word is discarded and D=4'b0001 (dir=0).
6. Assert rst_n=0 asynchronously after bit 2 of a frame, release it, then send a full frame 1001. Required: all outputs 0 during reset; the next delivery is D=4'b1001 with no stale bits.
